// File: rtl/sha_sched_pkg.sv
// sha_sched_pkg
// Shared types and default widths for the SHA-256 job scheduler.
// The job struct below is sized with the default widths; the scheduler
// builds its own job type from its actual parameters.

package sha_sched_pkg;

    localparam int unsigned DEF_FIFO_DEPTH     = 32'd4;
    localparam int unsigned DEF_ADDR_W         = 32'd16;
    localparam int unsigned DEF_TAG_W          = 32'd4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1024;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_REPORT    = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] msg;
        logic [DEF_ADDR_W-1:0] out;
        logic [DEF_TAG_W-1:0]  tag;
    } sha_job_t;

endpackage

// File: rtl/sha_job_fifo.sv
// sha_job_fifo
// Small synchronous FIFO of jobs. The head entry is presented
// combinationally on rdata; count is registered and full/empty derive from
// it, so they only change on a clock edge. Pushes into a full FIFO and pops
// from an empty FIFO are ignored.

module sha_job_fifo
    import sha_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter type         T     = sha_job_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T               mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           full_s;
    logic           empty_s;
    logic           do_push_s;
    logic           do_pop_s;

    // Qualify push/pop against the registered occupancy.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        do_push_s = push && !full_s;
        do_pop_s  = pop && !empty_s;
    end

    // Entry storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/sha_job_scheduler.sv
// sha_job_scheduler
// Buffers SHA-256 jobs and runs them one at a time on a single hash core.
// Jobs arrive on a valid/ready request port, wait in sha_job_fifo, are
// launched with a one-cycle core_start pulse once the core reports done,
// and are retired on a valid/ready completion port carrying the job tag.
// Optional build macro SHA_SCHED_TIMEOUT_EN adds a watchdog that retires a
// job with cpl_err = 1 after TIMEOUT_CYCLES cycles of waiting on the core.

module sha_job_scheduler
    import sha_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned TAG_W          = DEF_TAG_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_msg_addr,
    input  logic [ADDR_W-1:0]             req_out_addr,
    input  logic [TAG_W-1:0]              req_tag,
    output logic                          core_start,
    output logic [ADDR_W-1:0]             core_message_addr,
    output logic [ADDR_W-1:0]             core_output_addr,
    input  logic                          core_done,
    output logic                          cpl_valid,
    input  logic                          cpl_ready,
    output logic [TAG_W-1:0]              cpl_tag,
    output logic                          cpl_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   queue_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] msg;
        logic [ADDR_W-1:0] out;
        logic [TAG_W-1:0]  tag;
    } job_t;

    sched_state_t     state_r;
    job_t             job_r;
    job_t             req_job_s;
    job_t             head_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    count_s;
    logic             timeout_hit_s;
    logic             core_start_r;
    logic             cpl_valid_r;
    logic             cpl_err_r;
    logic [TAG_W-1:0] cpl_tag_r;
    logic             busy_r;

    // Request acceptance and launch decision; a full queue never takes a push.
    always_comb begin
        req_job_s.msg = req_msg_addr;
        req_job_s.out = req_out_addr;
        req_job_s.tag = req_tag;
        push_s        = req_valid && !fifo_full_s;
        pop_s         = (state_r == S_IDLE) && !fifo_empty_s && core_done;
    end

    sha_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (job_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (req_job_s),
        .rdata (head_s),
        .count (count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt_r;

    // Watchdog counter: cleared in S_LAUNCH, counts while waiting on the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= {TW{1'b0}};
        end else begin
            case (state_r)
                S_LAUNCH:    wd_cnt_r <= {TW{1'b0}};
                S_WAIT_BUSY,
                S_WAIT_DONE: wd_cnt_r <= wd_cnt_r + TW'(1);
                default:     wd_cnt_r <= wd_cnt_r;
            endcase
        end
    end

    // The counter reaches TIMEOUT_CYCLES on the edge that ends this cycle.
    always_comb begin
        if ((state_r == S_WAIT_BUSY) || (state_r == S_WAIT_DONE)) begin
            timeout_hit_s = (wd_cnt_r == TW'(TIMEOUT_CYCLES - 1));
        end else begin
            timeout_hit_s = 1'b0;
        end
    end
`else
    // No watchdog: a hung core is waited on indefinitely. TIMEOUT_CYCLES is
    // folded in only so both builds share one parameter list.
    always_comb begin
        timeout_hit_s = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
    end
`endif

    // Job sequencing FSM; every output it drives is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            job_r        <= '0;
            core_start_r <= 1'b0;
            cpl_valid_r  <= 1'b0;
            cpl_err_r    <= 1'b0;
            cpl_tag_r    <= {TAG_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        state_r      <= S_LAUNCH;
                        job_r        <= head_s;
                        core_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= S_IDLE;
                        core_start_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state_r      <= S_WAIT_BUSY;
                    core_start_r <= 1'b0;
                end
                S_WAIT_BUSY: begin
                    if (!core_done) begin
                        state_r <= S_WAIT_DONE;
                    end else if (timeout_hit_s) begin
                        state_r     <= S_REPORT;
                        cpl_valid_r <= 1'b1;
                        cpl_err_r   <= 1'b1;
                        cpl_tag_r   <= job_r.tag;
                    end else begin
                        state_r <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_DONE: begin
                    if (core_done) begin
                        state_r     <= S_REPORT;
                        cpl_valid_r <= 1'b1;
                        cpl_err_r   <= 1'b0;
                        cpl_tag_r   <= job_r.tag;
                    end else if (timeout_hit_s) begin
                        state_r     <= S_REPORT;
                        cpl_valid_r <= 1'b1;
                        cpl_err_r   <= 1'b1;
                        cpl_tag_r   <= job_r.tag;
                    end else begin
                        state_r <= S_WAIT_DONE;
                    end
                end
                S_REPORT: begin
                    if (cpl_ready) begin
                        state_r     <= S_IDLE;
                        cpl_valid_r <= 1'b0;
                        cpl_err_r   <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= S_REPORT;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    core_start_r <= 1'b0;
                    cpl_valid_r  <= 1'b0;
                    cpl_err_r    <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    // Core addresses come straight from the job registers so they stay put
    // for the whole job and between jobs.
    assign core_start        = core_start_r;
    assign core_message_addr = job_r.msg;
    assign core_output_addr  = job_r.out;
    assign cpl_valid         = cpl_valid_r;
    assign cpl_tag           = cpl_tag_r;
    assign cpl_err           = cpl_err_r;
    assign busy              = busy_r;
    assign queue_count       = count_s;
    assign req_ready         = !fifo_full_s;

endmodule

// File: tb/tb_sha_job_scheduler.sv
// tb_sha_job_scheduler
// Self-checking bench for sha_job_scheduler with a behavioural hash-core
// model. Define SHA_SCHED_TIMEOUT_EN to also exercise the watchdog.

module tb_sha_job_scheduler;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int TW    = 4;
    localparam int TMO   = 64;

    typedef struct packed {
        logic [AW-1:0] msg;
        logic [AW-1:0] out;
        logic [TW-1:0] tag;
    } tjob_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_msg_addr = '0;
    logic [AW-1:0] req_out_addr = '0;
    logic [TW-1:0] req_tag = '0;
    logic          core_start;
    logic [AW-1:0] core_message_addr;
    logic [AW-1:0] core_output_addr;
    logic          core_done;
    logic          cpl_valid;
    logic          cpl_ready = 1'b0;
    logic [TW-1:0] cpl_tag;
    logic          cpl_err;
    logic          busy;
    logic [2:0]    queue_count;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural core: done is high whenever idle; start makes it busy for
    // core_latency cycles. core_stall forces done low, core_kill aborts.
    logic core_busy = 1'b0;
    int   core_cnt = 0;
    int   core_latency = 10;
    bit   core_stall = 1'b0;
    bit   core_kill = 1'b0;

    assign core_done = !core_busy && !core_stall;

    always @(posedge clk) begin
        if (core_kill) begin
            core_busy <= 1'b0;
        end else if (core_start) begin
            core_busy <= 1'b1;
            core_cnt  <= core_latency;
        end else if (core_busy) begin
            if (core_cnt <= 1) core_busy <= 1'b0;
            core_cnt <= core_cnt - 1;
        end
    end

    always #5 clk = ~clk;

    sha_job_scheduler #(
        .FIFO_DEPTH     (DEPTH),
        .ADDR_W         (AW),
        .TAG_W          (TW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_msg_addr      (req_msg_addr),
        .req_out_addr      (req_out_addr),
        .req_tag           (req_tag),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done),
        .cpl_valid         (cpl_valid),
        .cpl_ready         (cpl_ready),
        .cpl_tag           (cpl_tag),
        .cpl_err           (cpl_err),
        .busy              (busy),
        .queue_count       (queue_count)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; cpl_ready = 1'b0; core_kill = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; core_kill = 1'b0;
    endtask

    // Present one job and hold it until accepted (bounded).
    task automatic push_job(input logic [AW-1:0] m, input logic [AW-1:0] o, input logic [TW-1:0] t);
        bit done_push = 1'b0;
        req_msg_addr = m; req_out_addr = o; req_tag = t; req_valid = 1'b1;
        for (int i = 0; i < 300 && !done_push; i++) begin
            if (req_ready) done_push = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!done_push) begin
            n_err++; $display("FAIL push_accept: tag %0d never accepted (ready stayed 0)", t);
        end
    endtask

    // Wait (bounded) for a completion, check its tag/err and consume it.
    task automatic take_cpl(input logic [TW-1:0] t, input logic e, input string nm);
        int c = 0;
        while (!cpl_valid && c < 500) begin @(negedge clk); c++; end
        n_cmp++;
        if (!cpl_valid) begin
            n_err++; $display("FAIL %s_wait: cpl_valid=0 after %0d cycles, required 1", nm, c);
        end else if (cpl_tag !== t || cpl_err !== e) begin
            n_err++; $display("FAIL %s_tag: tag=%0d err=%0b, required tag=%0d err=%0b", nm, cpl_tag, cpl_err, t, e);
        end
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %0b required 1", req_ready); end
        n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL rst_core_start: got %0b required 0", core_start); end
        n_cmp++; if (cpl_valid !== 1'b0) begin n_err++; $display("FAIL rst_cpl_valid: got %0b required 0", cpl_valid); end
        n_cmp++; if (cpl_err !== 1'b0) begin n_err++; $display("FAIL rst_cpl_err: got %0b required 0", cpl_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b required 0", busy); end
        n_cmp++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d required 0", queue_count); end
        n_cmp++; if (cpl_tag !== 4'd0) begin n_err++; $display("FAIL rst_cpl_tag: got %0d required 0", cpl_tag); end
        n_cmp++; if (core_message_addr !== 16'h0 || core_output_addr !== 16'h0) begin
            n_err++; $display("FAIL rst_addr: got %0h/%0h required 0/0", core_message_addr, core_output_addr);
        end
    endtask

    task automatic test_single_job();
        int cyc;
        do_reset();
        core_latency = 150; cpl_ready = 1'b0;
        req_valid = 1'b1; req_msg_addr = 16'h0000; req_out_addr = 16'h0100; req_tag = 4'd3;
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (queue_count !== 3'd1 || core_start !== 1'b0) begin
            n_err++; $display("FAIL single_accept: count=%0d start=%0b required 1/0", queue_count, core_start);
        end
        @(negedge clk);
        n_cmp++; if (core_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %0b required 1", core_start); end
        n_cmp++; if (core_message_addr !== 16'h0000 || core_output_addr !== 16'h0100) begin
            n_err++; $display("FAIL single_addr: got %0h/%0h required 0/100", core_message_addr, core_output_addr);
        end
        @(negedge clk);
        cyc = 1;
        n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %0b required 0", core_start); end
        while (!cpl_valid && cyc < 400) begin
            n_cmp++;
            if (core_message_addr !== 16'h0000 || core_output_addr !== 16'h0100 || core_start !== 1'b0) begin
                n_err++; $display("FAIL single_hold: addr %0h/%0h start %0b at cycle %0d", core_message_addr, core_output_addr, core_start, cyc);
            end
            @(negedge clk); cyc++;
        end
        n_cmp++; if (cyc !== 152) begin n_err++; $display("FAIL single_latency: cpl_valid after %0d cycles, required 152", cyc); end
        n_cmp++; if (cpl_tag !== 4'd3 || cpl_err !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_cpl: tag=%0d err=%0b busy=%0b required 3/0/1", cpl_tag, cpl_err, busy);
        end
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
        n_cmp++; if (cpl_valid !== 1'b0 || busy !== 1'b0 || core_output_addr !== 16'h0100) begin
            n_err++; $display("FAIL single_retire: valid=%0b busy=%0b out=%0h required 0/0/100", cpl_valid, busy, core_output_addr);
        end
    endtask

    task automatic test_fill_queue();
        logic [TW-1:0] got[$];
        bit any_start = 1'b0;
        do_reset();
        core_stall = 1'b1; core_latency = 5;
        for (int i = 0; i < 4; i++) push_job(16'h1000 + 16'(i), 16'h2000 + 16'(i), 4'(i));
        n_cmp++; if (queue_count !== 3'd4 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL fill_full: count=%0d ready=%0b required 4/0", queue_count, req_ready);
        end
        req_valid = 1'b1; req_msg_addr = 16'h1004; req_out_addr = 16'h2004; req_tag = 4'd4;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (core_start) any_start = 1'b1; end
        req_valid = 1'b0;
        n_cmp++; if (queue_count !== 3'd4 || any_start) begin
            n_err++; $display("FAIL fill_hold: count=%0d start_seen=%0b required 4/0", queue_count, any_start);
        end
        core_stall = 1'b0; cpl_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpl_valid) got.push_back(cpl_tag);
        end
        cpl_ready = 1'b0;
        n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL fill_cpl_count: got %0d completions required 4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== 4'(i)) begin n_err++; $display("FAIL fill_order: completion %0d tag %0d required %0d", i, got[i], i); end
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        do_reset();
        core_latency = 10; cpl_ready = 1'b0;
        push_job(16'hA000, 16'hA100, 4'd5);
        push_job(16'hB000, 16'hB100, 4'd6);
        while (!cpl_valid && c < 100) begin @(negedge clk); c++; end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (cpl_valid !== 1'b1 || cpl_tag !== 4'd5 || core_start !== 1'b0 || queue_count !== 3'd1) begin
                n_err++; $display("FAIL bp_stable: valid=%0b tag=%0d start=%0b count=%0d required 1/5/0/1", cpl_valid, cpl_tag, core_start, queue_count);
            end
            @(negedge clk);
        end
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
        n_cmp++; if (cpl_valid !== 1'b0 || core_start !== 1'b0) begin
            n_err++; $display("FAIL bp_gap: valid=%0b start=%0b required 0/0", cpl_valid, core_start);
        end
        @(negedge clk);
        n_cmp++; if (core_start !== 1'b1 || core_message_addr !== 16'hB000) begin
            n_err++; $display("FAIL bp_next_launch: start=%0b msg=%0h required 1/b000", core_start, core_message_addr);
        end
        take_cpl(4'd6, 1'b0, "bp_second");
    endtask

    task automatic test_start_gating();
        bit any_start = 1'b0;
        core_stall = 1'b1;
        do_reset();
        core_latency = 8;
        push_job(16'hC000, 16'hC100, 4'd9);
        for (int i = 0; i < 15; i++) begin
            if (core_start || busy) any_start = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (any_start) begin n_err++; $display("FAIL gate_hold: launch seen while core_done=0, required none"); end
        core_stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (core_start !== 1'b1) begin n_err++; $display("FAIL gate_release: start=%0b required 1", core_start); end
        take_cpl(4'd9, 1'b0, "gate");
    endtask

    task automatic test_mid_job_reset();
        bit seen = 1'b0;
        do_reset();
        core_latency = 200; cpl_ready = 1'b1;
        push_job(16'hD000, 16'hD100, 4'd1);
        push_job(16'hD010, 16'hD110, 4'd2);
        push_job(16'hD020, 16'hD120, 4'd3);
        for (int i = 0; i < 20; i++) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || queue_count !== 3'd2) begin
            n_err++; $display("FAIL mrst_pre: busy=%0b count=%0d required 1/2", busy, queue_count);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (queue_count !== 3'd0 || cpl_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL mrst_after: count=%0d valid=%0b busy=%0b ready=%0b required 0/0/0/1", queue_count, cpl_valid, busy, req_ready);
        end
        for (int i = 0; i < 300; i++) begin
            if (cpl_valid || core_start) seen = 1'b1;
            @(negedge clk);
        end
        cpl_ready = 1'b0;
        n_cmp++; if (seen) begin n_err++; $display("FAIL mrst_dropped: activity seen after reset, required none"); end
    endtask

    task automatic test_random();
        tjob_t q[$];
        tjob_t cur = '0;
        tjob_t pj = '0;
        bit inflight = 1'b0;
        bit pv = 1'b0, pr = 1'b0, pcv = 1'b0, pcr = 1'b0;
        int acc = 0, ncpl = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (pcv && pcr) begin inflight = 1'b0; ncpl++; end
            if (core_start) begin
                n_cmp++;
                if (inflight || q.size() == 0) begin
                    n_err++; $display("FAIL rnd_launch: illegal launch inflight=%0b queued=%0d", inflight, q.size());
                end else begin
                    cur = q.pop_front(); inflight = 1'b1;
                end
            end
            if (pv && pr) begin q.push_back(pj); acc++; end
            n_cmp++;
            if (queue_count !== 3'(q.size()) || req_ready !== (q.size() < DEPTH) || busy !== inflight) begin
                n_err++; $display("FAIL rnd_state: count=%0d ready=%0b busy=%0b required %0d/%0b/%0b", queue_count, req_ready, busy, q.size(), q.size() < DEPTH, inflight);
            end
            if (inflight) begin
                n_cmp++;
                if (core_message_addr !== cur.msg || core_output_addr !== cur.out) begin
                    n_err++; $display("FAIL rnd_addr: got %0h/%0h required %0h/%0h", core_message_addr, core_output_addr, cur.msg, cur.out);
                end
            end
            if (cpl_valid) begin
                n_cmp++;
                if (!inflight || cpl_tag !== cur.tag || cpl_err !== 1'b0) begin
                    n_err++; $display("FAIL rnd_cpl: tag=%0d err=%0b required %0d/0 (inflight=%0b)", cpl_tag, cpl_err, cur.tag, inflight);
                end
            end
            pr = req_ready; pcv = cpl_valid;
            if (pv && !pr) begin
                req_valid = 1'b1;
            end else if (c < 2500 && $urandom_range(0, 2) != 0) begin
                pj.msg = 16'($urandom()); pj.out = 16'($urandom()); pj.tag = 4'($urandom_range(0, 15));
                req_msg_addr = pj.msg; req_out_addr = pj.out; req_tag = pj.tag;
                req_valid = 1'b1; pv = 1'b1;
            end else begin
                req_valid = 1'b0; pv = 1'b0;
            end
            cpl_ready = ($urandom_range(0, 3) != 0);
            pcr = cpl_ready;
            core_latency = $urandom_range(2, 20);
        end
        req_valid = 1'b0; cpl_ready = 1'b0;
        n_cmp++;
        if (acc !== ncpl || q.size() != 0 || inflight || acc == 0) begin
            n_err++; $display("FAIL rnd_drain: accepted=%0d completed=%0d left=%0d inflight=%0b", acc, ncpl, q.size(), inflight);
        end
    endtask

`ifdef SHA_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int c = 0;
        bit any_start = 1'b0;
        do_reset();
        core_latency = 1000000; cpl_ready = 1'b0;
        push_job(16'hE000, 16'hE100, 4'd7);
        while (!core_start && c < 10) begin @(negedge clk); c++; end
        c = 0;
        while (!cpl_valid && c < 200) begin @(negedge clk); c++; end
        n_cmp++; if (c < 63 || c > 65) begin n_err++; $display("FAIL tmo_latency: cpl_valid after %0d cycles, required 64 +-1", c); end
        n_cmp++; if (cpl_valid !== 1'b1 || cpl_err !== 1'b1 || cpl_tag !== 4'd7) begin
            n_err++; $display("FAIL tmo_cpl: valid=%0b err=%0b tag=%0d required 1/1/7", cpl_valid, cpl_err, cpl_tag);
        end
        push_job(16'hE010, 16'hE110, 4'd8);
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin if (core_start) any_start = 1'b1; @(negedge clk); end
        n_cmp++; if (any_start) begin n_err++; $display("FAIL tmo_gate: launch while core still busy, required none"); end
        core_latency = 5; core_kill = 1'b1;
        @(negedge clk);
        core_kill = 1'b0;
        take_cpl(4'd8, 1'b0, "tmo_next");
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_fill_queue();
        test_backpressure();
        test_start_gating();
        test_mid_job_reset();
        test_random();
`ifdef SHA_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha_job_scheduler.md
# sha_job_scheduler

Queues SHA-256 hash jobs and sequences them one at a time onto a single `simplified_sha256` core. Each job is a (message address, output address, tag) triple. Jobs enter through a valid/ready request port and are buffered in a small FIFO. The scheduler drives the core's `start` and address inputs, tracks its `done` level, and returns the tag on a valid/ready completion port. It sits between the system-side command source and the hash core; memory traffic stays on the core's own port.

## Interface
- `FIFO_DEPTH`, 4: job queue entries; power of two, ≥2.
- `ADDR_W`, 16: width of message/output word addresses.
- `TAG_W`, 4: job tag width.
- `TIMEOUT_CYCLES`, 1024: watchdog limit; used only with `SHA_SCHED_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: job request present.
- `req_ready` out 1: queue can accept a job.
- `req_msg_addr` in ADDR_W: message base address.
- `req_out_addr` in ADDR_W: hash output base address.
- `req_tag` in TAG_W: job identifier.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_message_addr` out ADDR_W: drives the core's `message_addr`.
- `core_output_addr` out ADDR_W: drives the core's `output_addr`.
- `core_done` in 1: core `done` level; high whenever the core is in IDLE.
- `cpl_valid` out 1: completion available.
- `cpl_ready` in 1: completion consumed.
- `cpl_tag` out TAG_W: tag of the completed job.
- `cpl_err` out 1: job timed out.
- `busy` out 1: FSM is not in S_IDLE.
- `queue_count` out $clog2(FIFO_DEPTH)+1: number of occupied queue entries.

## Operation
- The block has one clock. Reset is synchronous and active-high.
- **Queue.** A request is accepted on a cycle where `req_valid && req_ready`.
  - `req_ready = (queue_count < FIFO_DEPTH)`. There is no full-queue bypass: a push into a full queue never happens, even on a pop cycle.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **S_IDLE.** Move to S_LAUNCH when the queue is non-empty and `core_done == 1`. Otherwise stay.
- **S_LAUNCH** (1 cycle):
  - Pop the head into the job registers (msg, out, tag).
  - Assert `core_start`.
  - Go to S_WAIT_BUSY.
- **S_WAIT_BUSY.** Go to S_WAIT_DONE on the first cycle with `core_done == 0`. Nominally this is the cycle after `core_start`.
- **S_WAIT_DONE.** Go to S_REPORT on the first cycle with `core_done == 1`.
- **S_REPORT.**
  - Hold `cpl_valid = 1` with a stable `cpl_tag`/`cpl_err` until `cpl_ready`.
  - On the handshake cycle, go to S_IDLE.
- **Address hold.** `core_message_addr`/`core_output_addr` come from the job registers. They stay stable from S_LAUNCH through S_REPORT, because the core samples `output_addr` late in the job. Between jobs they hold the last value.
- **Reset.**
  - Scheduler reset flushes the queue, drops any in-flight job without a completion, and does not reset the core.
  - After reset the FSM waits in S_IDLE for `core_done == 1` before any launch.
- **Reset values.**
  - `req_ready` = 1 (queue empty).
  - `core_start`, `cpl_valid`, `cpl_err`, `busy`, `queue_count` = 0.
  - `cpl_tag`, `core_message_addr`, `core_output_addr` = 0.

## Timing
- `core_start` is registered. It is high for exactly the one cycle the FSM is in S_LAUNCH.
- A job accepted at edge N into an empty queue with an idle core:
  - `queue_count` = 1 after edge N;
  - S_LAUNCH and `core_start` = 1 in the cycle after edge N+1.
- `cpl_valid` rises the cycle after `core_done` is seen high in S_WAIT_DONE.
- Back-to-back throughput: the next S_LAUNCH comes no earlier than 2 cycles after the completion handshake.
- `req_ready` follows `queue_count` from the previous edge; it is not combinationally dependent on the pop.

## Configuration
- **With `SHA_SCHED_TIMEOUT_EN` defined:**
  - A counter clears in S_LAUNCH and increments in S_WAIT_BUSY/S_WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to S_REPORT with `cpl_err = 1`.
  - The next launch still waits for `core_done == 1`.
- **Without it:** there is no counter, `cpl_err` is tied to 0, and the wait is unbounded.

## Structure
- Package `sha_sched_pkg` holds:
  - the state enum `sched_state_t` (S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_REPORT);
  - the job struct `sha_job_t` {msg, out, tag};
  - the default widths.
- Sub-module `sha_job_fifo`: parameterised sync FIFO of `sha_job_t` with push/pop/count/full/empty. The FSM lives in the top module.

## Test plan
- **Single job.** Push msg=0x0000, out=0x0100, tag=3; the core model finishes after 150 cycles.
  - `core_start` is high for 1 cycle, 2 cycles after acceptance.
  - Addresses are held for the whole job.
  - `cpl_tag` = 3, `cpl_err` = 0.
- **Fill queue.** With the core stalled, push 5 jobs.
  - After the 4th push the queue holds 4 and `req_ready` = 0; the 5th is held off.
  - Completions come out in order with tags 0,1,2,3.
- **Completion backpressure.** Hold `cpl_ready` = 0 for 20 cycles.
  - `cpl_valid` and `cpl_tag` stay stable.
  - No new `core_start` until the handshake.
- **Start gating.** Hold `core_done` = 0 from reset, then push a job.
  - No `core_start` is issued until `core_done` rises.
- **Mid-job reset.** Assert `reset` during S_WAIT_DONE with 2 jobs queued.
  - `queue_count` = 0, `cpl_valid` = 0, `busy` = 0 the cycle after.
  - No completion is produced for the dropped jobs.
- **Timeout (`SHA_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES = 64).** Run a core that never returns `done`.
  - `cpl_valid` rises with `cpl_err` = 1 at 64 cycles after S_LAUNCH (±1 cycle for the registered S_REPORT transition).
